// File: rtl/vga_sync_gen.sv
// VGA timing generator with registered TinyVGA PMOD output packing.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIX_DIV  = 1,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic [5:0]    rgb_in,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          display_on,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic [7:0]    vga_out,
    output logic [7:0]    frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic          ACT      = (SYNC_POL != 0);

    logic [DW-1:0] div_cnt;
    logic          hs_act;
    logic          vs_act;
    logic [5:0]    colour;

    always_ff @(posedge clk) begin
        if (sys_rst)       div_cnt <= '0;
        else if (pix_tick) div_cnt <= '0;
        else               div_cnt <= div_cnt + 1'b1;
    end

    assign pix_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            hpos <= '0;
            vpos <= '0;
        end else if (pix_tick) begin
            if (hpos == H_LAST) begin
                hpos <= '0;
                vpos <= (vpos == V_LAST) ? '0 : vpos + 1'b1;
            end else begin
                hpos <= hpos + 1'b1;
            end
        end
    end

    assign display_on  = (hpos < H_VIS) && (vpos < V_VIS);
    assign line_start  = pix_tick && (hpos == '0);
    assign frame_start = line_start && (vpos == '0);
    assign hs_act      = (hpos >= HS_BEG) && (hpos < HS_END);
    assign vs_act      = (vpos >= VS_BEG) && (vpos < VS_END);

    // Output stage samples the current pixel, so it lags the counters by one tick.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            hsync  <= ~ACT;
            vsync  <= ~ACT;
            colour <= '0;
        end else if (pix_tick) begin
            hsync  <= hs_act ? ACT : ~ACT;
            vsync  <= vs_act ? ACT : ~ACT;
            colour <= display_on ? rgb_in : '0;
        end
    end

    // rgb_in is {R1,R0,G1,G0,B1,B0}; PMOD order is {HS,B0,G0,R0,VS,B1,G1,R1}.
    assign vga_out = {hsync, colour[0], colour[2], colour[4],
                      vsync, colour[1], colour[3], colour[5]};

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fcnt;
    logic       seen_first;

    // The first frame_start after reset marks frame 0 rather than counting.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            fcnt       <= '0;
            seen_first <= 1'b0;
        end else if (frame_start) begin
            seen_first <= 1'b1;
            if (seen_first) fcnt <= fcnt + 8'd1;
        end
    end

    assign frame_cnt = fcnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Parametrised VGA timing and output-packing engine for the crossyroad game core. It generates horizontal and vertical pixel counters, sync pulses and blanking, plus line and frame strobes. It registers the game's 6-bit colour into the TinyVGA PMOD pin order, so the top level drives uo_out straight from vga_out. Timing, sync polarity and the pixel-clock divide ratio are all parameters, which lets the same block cover 640x480 and other modes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level: 0 = active-low, 1 = active-high
PIX_DIV, 1, clk cycles per pixel (>=1)
CW, 10, counter width; must hold max(H_TOTAL, V_TOTAL)-1

Ports:
clk  in  1  system clock
sys_rst  in  1  reset; synchronous, active-high
rgb_in  in  6  {R1,R0,G1,G0,B1,B0} for the current hpos/vpos
hpos  out  CW  current pixel column, 0..H_TOTAL-1
vpos  out  CW  current line, 0..V_TOTAL-1
display_on  out  1  combinational: hpos<H_ACTIVE && vpos<V_ACTIVE
pix_tick  out  1  pixel-advance enable
line_start  out  1  one-clk pulse: pix_tick && hpos==0
frame_start  out  1  one-clk pulse: pix_tick && hpos==0 && vpos==0
hsync  out  1  registered hsync (polarity per SYNC_POL)
vsync  out  1  registered vsync
vga_out  out  8  registered PMOD: [7]=hsync [6]=B0 [5]=G0 [4]=R0 [3]=vsync [2]=B1 [1]=G1 [0]=R1
frame_cnt  out  8  frame counter (see Optional Feature)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V_ parameters.
- Divider: div_cnt counts 0..PIX_DIV-1. pix_tick = (div_cnt==PIX_DIV-1). With PIX_DIV=1, pix_tick is constantly 1.
- On pix_tick, hpos increments. At H_TOTAL-1 it wraps to 0 and vpos increments. vpos wraps to 0 from V_TOTAL-1. Between ticks all counters hold.
- Sync decode, unregistered, from the current counters:
  - hs_act when H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - vs_act when V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC.
- Output register, loaded on pix_tick only:
  - hsync = hs_act XNOR SYNC_POL (active level when hs_act=1). vsync uses vs_act the same way.
  - colour bits = rgb_in if display_on, else 0. Colour outside the active area is forced to 0.
- Latency: hsync, vsync and vga_out lag hpos/vpos by exactly one pixel tick. rgb_in must be valid combinationally in the same cycle as hpos/vpos.
- Strobes are combinational and high for exactly one clk cycle per event, regardless of PIX_DIV.
- Reset (sync, any cycle, overrides pix_tick):
  - div_cnt=0, hpos=0, vpos=0, frame_cnt=0.
  - hsync and vsync go to their inactive level, colour=0. With SYNC_POL=0, vga_out=8'h88.
  - The first cycle after reset release is hpos=0, vpos=0. With PIX_DIV=1, frame_start is high in that cycle.
- Mid-frame reset restarts the frame at (0,0); no partial-line recovery.
- Counter arithmetic is unsigned CW-bit. No overflow is possible when CW is sized correctly.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- Defined: frame_cnt increments by 1 in the cycle where frame_start is high, except on the first frame_start after reset. It wraps 255->0 and resets to 0.
- Undefined: frame_cnt is tied to 8'h00 and no counter register is built. Used for game animation timing.

Test Plan:
- Reset: hold sys_rst 3 cycles, default params -> vga_out=8'h88, hpos=0, vpos=0, hsync=vsync=1; release -> frame_start=1 in the first cycle.
- Line timing, default params:
  - hsync=0 for exactly 96 clks, first low at the cycle after hpos==656.
  - line_start period 800 clks.
  - frame_start period 420000 clks.
  - vsync=0 for exactly 1600 clks, beginning at line 490.
- Colour gating: rgb_in=6'h3F constantly -> vga_out=8'hFF while displaying; vga_out=8'h88 in porches; vga_out=8'h08 during hsync outside vsync.
- PIX_DIV=2: hpos advances every 2 clks, pix_tick 50% duty, frame_start period 840000 clks, outputs stable across the non-tick cycle.
- Mid-frame reset: assert sys_rst at hpos=300, vpos=200 -> next cycle hpos=0, vpos=0, vga_out=8'h88, frame_cnt=0.
- VGA_FRAME_COUNTER_EN defined -> frame_cnt reads 1 after the 2nd frame_start and wraps to 0 after 257 frame_starts; undefined -> frame_cnt stays 0.
